// File: rtl/pipeline_ex_stage5.sv
// Execute stage: operand select, ALU, branch/jump resolution and the EX/MEM pipeline register.
// Redirect is resolved combinationally in the same cycle the instruction sits in ID/EX.
module pipeline_ex_stage5 (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [63:0] pc_IDR,
   input  logic [63:0] reg_data1_IDR,
   input  logic [63:0] reg_data2_IDR,
   input  logic [63:0] imm_IDR,
   input  logic [4:0]  rd_IDR,
   input  logic        rf_wr_en_IDR,
   input  logic        do_jump_IDR,
   input  logic        is_branch_IDR,
   input  logic        alu_a_sel_IDR,
   input  logic        alu_b_sel_IDR,
   input  logic [3:0]  alu_ctrl_IDR,
   input  logic [2:0]  BrType_IDR,
   input  logic [1:0]  rf_wr_sel_IDR,
   input  logic [2:0]  dm_rd_ctrl_IDR,
   input  logic [2:0]  dm_wr_ctrl_IDR,
   output logic [63:0] alu_result_EX,
   output logic [63:0] pc_EX,
   output logic [63:0] store_data_EX,
   output logic [4:0]  rd_EX,
   output logic        rf_wr_en_EX,
   output logic [1:0]  rf_wr_sel_EX,
   output logic [2:0]  dm_rd_ctrl_EX,
   output logic [2:0]  dm_wr_ctrl_EX,
   output logic        valid_EX,
   output logic        redirect,
   output logic [63:0] redirect_pc
);

   logic [63:0] op_a;
   logic [63:0] op_b;
   logic [5:0]  shamt;
   logic [63:0] alu_result;
   logic        br_true;
   logic        taken;

   assign op_a  = alu_a_sel_IDR ? pc_IDR : reg_data1_IDR;
   assign op_b  = alu_b_sel_IDR ? imm_IDR : reg_data2_IDR;
   assign shamt = op_b[5:0];

   always_comb begin
      alu_result = 64'd0;
      case (alu_ctrl_IDR)
         4'd0:    alu_result = op_a + op_b;
         4'd1:    alu_result = op_a - op_b;
         4'd2:    alu_result = op_a << shamt;
         4'd3:    alu_result = {63'd0, $signed(op_a) < $signed(op_b)};
         4'd4:    alu_result = {63'd0, op_a < op_b};
         4'd5:    alu_result = op_a ^ op_b;
         4'd6:    alu_result = op_a >> shamt;
         4'd7:    alu_result = $unsigned($signed(op_a) >>> shamt);
         4'd8:    alu_result = op_a | op_b;
         4'd9:    alu_result = op_a & op_b;
         4'd10:   alu_result = op_b;
         default: alu_result = 64'd0;
      endcase
   end

   // Branches always compare the register operands, never the muxed ALU inputs.
   always_comb begin
      br_true = 1'b0;
      case (BrType_IDR)
         3'd0:    br_true = (reg_data1_IDR == reg_data2_IDR);
         3'd1:    br_true = (reg_data1_IDR != reg_data2_IDR);
         3'd4:    br_true = ($signed(reg_data1_IDR) <  $signed(reg_data2_IDR));
         3'd5:    br_true = ($signed(reg_data1_IDR) >= $signed(reg_data2_IDR));
         3'd6:    br_true = (reg_data1_IDR <  reg_data2_IDR);
         3'd7:    br_true = (reg_data1_IDR >= reg_data2_IDR);
         default: br_true = 1'b0;
      endcase
   end

   assign taken       = is_branch_IDR & br_true;
   assign redirect    = (do_jump_IDR | taken) & ~flush & ~stall;
   assign redirect_pc = do_jump_IDR ? {alu_result[63:1], 1'b0} : (pc_IDR + imm_IDR);

   // Stall freezes the slot even when flush is also asserted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_result_EX <= 64'd0;
         pc_EX         <= 64'd0;
         store_data_EX <= 64'd0;
         rd_EX         <= 5'd0;
         rf_wr_en_EX   <= 1'b0;
         rf_wr_sel_EX  <= 2'd0;
         dm_rd_ctrl_EX <= 3'd0;
         dm_wr_ctrl_EX <= 3'd0;
         valid_EX      <= 1'b0;
      end else if (!stall) begin
         if (flush) begin
            alu_result_EX <= 64'd0;
            pc_EX         <= 64'd0;
            store_data_EX <= 64'd0;
            rd_EX         <= 5'd0;
            rf_wr_en_EX   <= 1'b0;
            rf_wr_sel_EX  <= 2'd0;
            dm_rd_ctrl_EX <= 3'd0;
            dm_wr_ctrl_EX <= 3'd0;
            valid_EX      <= 1'b0;
         end else begin
            alu_result_EX <= alu_result;
            pc_EX         <= pc_IDR;
            store_data_EX <= reg_data2_IDR;
            rd_EX         <= rd_IDR;
            rf_wr_en_EX   <= rf_wr_en_IDR & (rd_IDR != 5'd0);
            rf_wr_sel_EX  <= rf_wr_sel_IDR;
            dm_rd_ctrl_EX <= dm_rd_ctrl_IDR;
            dm_wr_ctrl_EX <= dm_wr_ctrl_IDR;
            valid_EX      <= 1'b1;
         end
      end
   end

endmodule

// File: doc/pipeline_ex_stage5.md
PIPELINE_EX_STAGE5 -- requirements
Module: pipeline_ex_stage5

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports below, clock and reset first.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 stall, flush  in  1 each  hold EX/MEM register; insert bubble.
REQ-005 pc_IDR, reg_data1_IDR, reg_data2_IDR, imm_IDR  in  64 each  PC, forwarded rs1/rs2 data, immediate.
REQ-006 rd_IDR  in  5  destination register.
REQ-007 rf_wr_en_IDR, do_jump_IDR, is_branch_IDR, alu_a_sel_IDR, alu_b_sel_IDR  in  1 each  control bits.
REQ-008 alu_ctrl_IDR  in  4; BrType_IDR  in  3; rf_wr_sel_IDR  in  2; dm_rd_ctrl_IDR, dm_wr_ctrl_IDR  in  3 each.
REQ-009 alu_result_EX, pc_EX, store_data_EX  out  64 each  registered ALU result, PC, rs2 data.
REQ-010 rd_EX  out  5; rf_wr_en_EX  out  1; rf_wr_sel_EX  out  2; dm_rd_ctrl_EX, dm_wr_ctrl_EX  out  3 each  registered pass-through.
REQ-011 valid_EX  out  1  registered: EX/MEM slot holds a real instruction.
REQ-012 redirect  out  1  combinational: taken branch or jump resolved this cycle.
REQ-013 redirect_pc  out  64  combinational redirect target.

Function
REQ-014 Operand A SHALL be pc_IDR when alu_a_sel_IDR=1, else reg_data1_IDR; operand B SHALL be imm_IDR when alu_b_sel_IDR=1, else reg_data2_IDR.
REQ-015 alu_ctrl codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 pass B; 11-15 SHALL yield 0.
REQ-016 Arithmetic is 64-bit modulo 2^64; shift amount = B[5:0]; SLT signed, SLTU unsigned; result 1 or 0.
REQ-017 Branch compare uses reg_data1_IDR vs reg_data2_IDR; BrType: 0 EQ, 1 NE, 4 LT, 5 GE, 6 LTU, 7 GEU; 2 and 3 SHALL never be taken.
REQ-018 taken = is_branch_IDR & compare-true; redirect = (do_jump_IDR | taken) & ~flush & ~stall.
REQ-019 redirect_pc = pc_IDR + imm_IDR for a branch; = ALU result with bit 0 cleared for a jump; do_jump_IDR has priority over is_branch_IDR.
REQ-020 On rising clk with stall=1: all registered outputs SHALL hold, regardless of flush.
REQ-021 With stall=0, flush=1: valid_EX, rf_wr_en_EX, dm_rd_ctrl_EX, dm_wr_ctrl_EX, rd_EX SHALL load 0; data outputs SHALL load 0.
REQ-022 With stall=0, flush=0: all registered outputs SHALL load next-state values, valid_EX=1; latency IDR->EX/MEM exactly 1 cycle.
REQ-023 store_data_EX SHALL be reg_data2_IDR unmodified; pc_EX = pc_IDR.
REQ-024 rd_IDR=0 SHALL force rf_wr_en_EX to 0 on load.

Reset
REQ-025 reset=0 SHALL immediately, without clk, clear every registered output to 0, including valid_EX.
REQ-026 Reset mid-operation SHALL discard the held instruction; first load after release follows REQ-020 to REQ-022.
REQ-027 redirect SHALL stay combinational and is not gated by reset; upstream ignores it while reset=0.

Verification
REQ-028 ADD: A=5, B=imm 7, alu_b_sel=1, ctrl 0 -> next cycle alu_result_EX=12, valid_EX=1.
REQ-029 SRA: A=0x8000_0000_0000_0000, B=4, ctrl 7 -> alu_result_EX=0xF800_0000_0000_0000.
REQ-030 BLT: rs1=-1, rs2=1, is_branch=1, BrType 4, pc=0x100, imm=0x20 -> redirect=1, redirect_pc=0x120 same cycle; BLTU on same operands -> redirect=0.
REQ-031 JALR: alu_a_sel=0, rs1=0x1001, imm=4, do_jump=1 -> redirect_pc=0x1004; do_jump and is_branch both 1 -> jump target wins.
REQ-032 stall=1 with flush=1 for 3 cycles -> outputs frozen, redirect=0; then flush only -> valid_EX=0, rf_wr_en_EX=0, dm_wr_ctrl_EX=0.
REQ-033 Assert reset=0 between clk edges with valid_EX=1 -> all outputs 0 before next edge; rd_IDR=0 with rf_wr_en_IDR=1 -> rf_wr_en_EX=0.
